// File: rtl/pwm_capture_pkg.sv
// Shared register-map constants and channel FSM state type for the PWM
// input-capture peripheral.
package pwm_capture_pkg;

    localparam logic [1:0] CTRL_IDX      = 2'd0;
    localparam logic [1:0] STATUS_IDX    = 2'd1;
    localparam logic [1:0] PERIOD_IDX    = 2'd2;
    localparam logic [1:0] HIGH_IDX      = 2'd3;
    localparam int         REGS_PER_CHAN = 4;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int STAT_VALID_BIT  = 0;
    localparam int STAT_OVF_BIT    = 1;
    localparam int STAT_LEVEL_BIT  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } cap_state_t;

endpackage

// File: rtl/pwm_capture_channel.sv
// One capture channel: synchronizer, edge detect, measurement FSM and the
// PERIOD/HIGH/valid/overflow result storage.
module capture_channel
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             cap_in,
    input  logic             enable,
    input  logic             clr_valid,
    input  logic             clr_ovf,
    output logic [CNT_W-1:0] period_r,
    output logic [CNT_W-1:0] high_r,
    output logic             valid_r,
    output logic             ovf_r,
    output logic             level_s
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    cap_state_t       state_r;
    logic             sync1_r, sync2_r, sync3_r;
    logic             rise_s, fall_s, capture_s;
    logic [CNT_W-1:0] cnt_r, hi_tmp_r, cnt_inc_s;

    // Edge detect on the synchronized input and saturating counter increment.
    always_comb begin
        rise_s    = sync2_r & ~sync3_r;
        fall_s    = ~sync2_r & sync3_r;
        capture_s = (state_r == MEAS) & enable & rise_s;
        cnt_inc_s = (cnt_r == CNT_MAX) ? CNT_MAX : cnt_r + CNT_W'(1);
    end

    assign level_s = sync2_r;

    // Two-flop synchronizer plus a delay flop for edge detection.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
        end else begin
            sync1_r <= cap_in;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    // Measurement FSM with its counters and result registers.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            hi_tmp_r <= '0;
            period_r <= '0;
            high_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_r    <= '0;
                    hi_tmp_r <= '0;
                    if (enable) state_r <= ARM;
                end
                ARM: begin
                    if (!enable) begin
                        state_r <= IDLE;
                    end else if (rise_s) begin
                        cnt_r    <= '0;
                        hi_tmp_r <= '0;
                        state_r  <= MEAS;
                    end
                end
                MEAS: begin
                    if (!enable) begin
                        state_r  <= IDLE;
                        cnt_r    <= '0;
                        hi_tmp_r <= '0;
                    end else if (rise_s) begin
                        period_r <= cnt_inc_s;
                        high_r   <= hi_tmp_r;
                        cnt_r    <= '0;
                        hi_tmp_r <= '0;
                    end else begin
                        cnt_r <= cnt_inc_s;
                        if (fall_s) hi_tmp_r <= cnt_inc_s;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    cnt_r    <= '0;
                    hi_tmp_r <= '0;
                end
            endcase
        end
    end

    // Sticky status flags; a capture in the same cycle beats a W1C.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            valid_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            if (capture_s)      valid_r <= 1'b1;
            else if (clr_valid) valid_r <= 1'b0;

            if (capture_s && (cnt_r == CNT_MAX)) ovf_r <= 1'b1;
            else if (clr_ovf)                    ovf_r <= 1'b0;
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// APB input-capture peripheral: register decode, CTRL storage, read mux and
// interrupt combine around NUM_CHANNELS capture channels.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int CNT_W        = 32
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic [31:0]             paddr,
    input  logic [31:0]             pwdata,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    output logic [31:0]             prdata,
    input  logic [NUM_CHANNELS-1:0] cap_in,
    output logic                    irq
);

    logic                    wr_s, in_range_s;
    logic [2:0]              chan_s;
    logic [1:0]              reg_s;
    logic [NUM_CHANNELS-1:0] en_r, irq_en_r;
    logic [NUM_CHANNELS-1:0] clr_valid_s, clr_ovf_s, valid_s, ovf_s, level_s;
    logic [CNT_W-1:0]        period_s [NUM_CHANNELS];
    logic [CNT_W-1:0]        high_s   [NUM_CHANNELS];
    logic                    sel_en_s, sel_irq_en_s, sel_valid_s, sel_ovf_s, sel_level_s;
    logic [CNT_W-1:0]        sel_period_s, sel_high_s;
    logic                    unused_s;

    assign unused_s = ^{paddr[1:0], pwdata[31:2]};

    // Address decode and per-channel W1C strobes.
    always_comb begin
        wr_s        = psel & penable & pwrite;
        chan_s      = paddr[6:4];
        reg_s       = paddr[3:2];
        in_range_s  = (paddr[31:4] < 28'(NUM_CHANNELS));
        clr_valid_s = '0;
        clr_ovf_s   = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (wr_s && in_range_s && (chan_s == 3'(c)) && (reg_s == STATUS_IDX)) begin
                clr_valid_s[c] = pwdata[STAT_VALID_BIT];
                clr_ovf_s[c]   = pwdata[STAT_OVF_BIT];
            end else begin
                clr_valid_s[c] = 1'b0;
                clr_ovf_s[c]   = 1'b0;
            end
        end
    end

    // CTRL registers.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            en_r     <= '0;
            irq_en_r <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (wr_s && in_range_s && (chan_s == 3'(c)) && (reg_s == CTRL_IDX)) begin
                    en_r[c]     <= pwdata[CTRL_EN_BIT];
                    irq_en_r[c] <= pwdata[CTRL_IRQ_EN_BIT];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
        capture_channel #(.CNT_W(CNT_W)) u_chan (
            .clk       (clk),
            .n_rst     (n_rst),
            .cap_in    (cap_in[g]),
            .enable    (en_r[g]),
            .clr_valid (clr_valid_s[g]),
            .clr_ovf   (clr_ovf_s[g]),
            .period_r  (period_s[g]),
            .high_r    (high_s[g]),
            .valid_r   (valid_s[g]),
            .ovf_r     (ovf_s[g]),
            .level_s   (level_s[g])
        );
    end

    // AND-OR select of the addressed channel, then the register read mux.
    always_comb begin
        sel_en_s     = 1'b0;
        sel_irq_en_s = 1'b0;
        sel_valid_s  = 1'b0;
        sel_ovf_s    = 1'b0;
        sel_level_s  = 1'b0;
        sel_period_s = '0;
        sel_high_s   = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            sel_en_s     = sel_en_s     | (en_r[c]     & (chan_s == 3'(c)));
            sel_irq_en_s = sel_irq_en_s | (irq_en_r[c] & (chan_s == 3'(c)));
            sel_valid_s  = sel_valid_s  | (valid_s[c]  & (chan_s == 3'(c)));
            sel_ovf_s    = sel_ovf_s    | (ovf_s[c]    & (chan_s == 3'(c)));
            sel_level_s  = sel_level_s  | (level_s[c]  & (chan_s == 3'(c)));
            sel_period_s = sel_period_s | (period_s[c] & {CNT_W{chan_s == 3'(c)}});
            sel_high_s   = sel_high_s   | (high_s[c]   & {CNT_W{chan_s == 3'(c)}});
        end

        prdata = 32'd0;
        if (psel && in_range_s) begin
            case (reg_s)
                CTRL_IDX: begin
                    prdata[CTRL_EN_BIT]     = sel_en_s;
                    prdata[CTRL_IRQ_EN_BIT] = sel_irq_en_s;
                end
                STATUS_IDX: begin
                    prdata[STAT_VALID_BIT] = sel_valid_s;
                    prdata[STAT_OVF_BIT]   = sel_ovf_s;
                    prdata[STAT_LEVEL_BIT] = sel_level_s;
                end
                PERIOD_IDX: prdata[CNT_W-1:0] = sel_period_s;
                HIGH_IDX:   prdata[CNT_W-1:0] = sel_high_s;
                default:    prdata = 32'd0;
            endcase
        end else begin
            prdata = 32'd0;
        end
    end

    assign irq = |(valid_s & irq_en_r);

endmodule

// File: tb/tb_pwm_capture.sv
// Directed self-checking bench for pwm_capture (4 channels, 8-bit counters).
module tb_pwm_capture;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [31:0] paddr, pwdata, prdata;
    logic        psel, penable, pwrite, irq;
    logic [3:0]  cap_in;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [3:0] gen_en;
    int gen_p [4];
    int gen_h [4];
    int gen_ph[4];

    always #5 clk = ~clk;

    pwm_capture #(.NUM_CHANNELS(4), .CNT_W(8)) dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .prdata  (prdata),
        .cap_in  (cap_in),
        .irq     (irq)
    );

    // Every cycle of the bench passes through here so waveforms keep running
    // during bus accesses.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                if (gen_en[c]) begin
                    cap_in[c] = (gen_ph[c] < gen_h[c]);
                    gen_ph[c] = (gen_ph[c] + 1 >= gen_p[c]) ? 0 : gen_ph[c] + 1;
                end
            end
        end
    endtask

    task automatic gen_start(input int c, input int p, input int h);
        gen_p[c] = p; gen_h[c] = h; gen_ph[c] = 0; gen_en[c] = 1'b1;
    endtask

    task automatic gen_stop(input int c);
        gen_en[c] = 1'b0; cap_in[c] = 1'b0;
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
        step(1);
        penable = 1'b1;
        step(1);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
        step(1);
        penable = 1'b1;
        #1 d = prdata;
        step(1);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        n_rst = 1'b0;
        step(2);
        vec_cnt++; if (irq !== 1'b0) begin err_cnt++; $display("FAIL reset_irq_in_reset: got %b expected 0", irq); end
        n_rst = 1'b1;
        step(1);
        for (int a = 0; a < 16; a++) begin
            apb_read(32'(a * 4), rd);
            vec_cnt++; if (rd !== 32'h0) begin err_cnt++; $display("FAIL reset_read addr %h: got %h expected 0", a * 4, rd); end
        end
        apb_read(32'h40, rd);
        vec_cnt++; if (rd !== 32'h0) begin err_cnt++; $display("FAIL reset_oor_0x40: got %h expected 0", rd); end
        vec_cnt++; if (irq !== 1'b0) begin err_cnt++; $display("FAIL reset_irq: got %b expected 0", irq); end
    endtask

    task automatic test_basic();
        logic [31:0] rd;
        apb_write(32'h00, 32'h3);
        gen_start(0, 16, 4);
        step(60);
        gen_stop(0);
        step(20);
        apb_read(32'h08, rd);
        vec_cnt++; if (rd !== 32'h10) begin err_cnt++; $display("FAIL basic_period: got %h expected 10", rd); end
        apb_read(32'h0C, rd);
        vec_cnt++; if (rd !== 32'h4) begin err_cnt++; $display("FAIL basic_high: got %h expected 4", rd); end
        apb_read(32'h04, rd);
        vec_cnt++; if (rd !== 32'h1) begin err_cnt++; $display("FAIL basic_status: got %h expected 1", rd); end
        vec_cnt++; if (irq !== 1'b1) begin err_cnt++; $display("FAIL basic_irq_set: got %b expected 1", irq); end
        psel = 1'b0; paddr = 32'h08; #1;
        vec_cnt++; if (prdata !== 32'h0) begin err_cnt++; $display("FAIL basic_psel_low: got %h expected 0", prdata); end
        apb_write(32'h04, 32'h1);
        #1;
        vec_cnt++; if (irq !== 1'b0) begin err_cnt++; $display("FAIL basic_irq_clr: got %b expected 0", irq); end
        apb_read(32'h04, rd);
        vec_cnt++; if (rd !== 32'h0) begin err_cnt++; $display("FAIL basic_status_clr: got %h expected 0", rd); end
        apb_write(32'h00, 32'h0);
    endtask

    task automatic test_independence();
        logic [31:0] rd;
        int exp_h[4] = '{1, 4, 8, 10};
        for (int c = 0; c < 4; c++) begin
            apb_write(32'(c * 16), 32'h1);
            gen_start(c, 16, exp_h[c]);
        end
        step(60);
        for (int c = 0; c < 4; c++) begin
            apb_read(32'(c * 16 + 8), rd);
            vec_cnt++; if (rd !== 32'h10) begin err_cnt++; $display("FAIL indep_period ch%0d: got %h expected 10", c, rd); end
            apb_read(32'(c * 16 + 12), rd);
            vec_cnt++; if (rd !== 32'(exp_h[c])) begin err_cnt++; $display("FAIL indep_high ch%0d: got %h expected %h", c, rd, exp_h[c]); end
        end
        apb_write(32'h20, 32'h0);
        for (int c = 0; c < 4; c++) apb_write(32'(c * 16 + 4), 32'h3);
        step(40);
        for (int c = 0; c < 4; c++) begin
            apb_read(32'(c * 16), rd);
            vec_cnt++; if (rd !== ((c == 2) ? 32'h0 : 32'h1)) begin err_cnt++; $display("FAIL indep_ctrl ch%0d: got %h", c, rd); end
            apb_read(32'(c * 16 + 4), rd);
            vec_cnt++; if (rd[0] !== ((c == 2) ? 1'b0 : 1'b1)) begin err_cnt++; $display("FAIL indep_valid ch%0d: got %b", c, rd[0]); end
        end
        for (int c = 0; c < 4; c++) begin
            gen_stop(c);
            apb_write(32'(c * 16), 32'h0);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        apb_write(32'h10, 32'h1);
        gen_start(1, 300, 100);
        step(650);
        gen_stop(1);
        step(10);
        apb_read(32'h18, rd);
        vec_cnt++; if (rd !== 32'hFF) begin err_cnt++; $display("FAIL ovf_period: got %h expected ff", rd); end
        apb_read(32'h1C, rd);
        vec_cnt++; if (rd !== 32'h64) begin err_cnt++; $display("FAIL ovf_high: got %h expected 64", rd); end
        apb_read(32'h14, rd);
        vec_cnt++; if (rd !== 32'h3) begin err_cnt++; $display("FAIL ovf_status: got %h expected 3", rd); end
        apb_write(32'h14, 32'h2);
        apb_read(32'h14, rd);
        vec_cnt++; if (rd !== 32'h1) begin err_cnt++; $display("FAIL ovf_w1c: got %h expected 1", rd); end
        apb_write(32'h10, 32'h0);
    endtask

    task automatic test_toggle();
        logic [31:0] rd;
        apb_write(32'h30, 32'h1);
        gen_start(3, 2, 1);
        step(20);
        gen_stop(3);
        step(5);
        apb_read(32'h38, rd);
        vec_cnt++; if (rd !== 32'h2) begin err_cnt++; $display("FAIL toggle_period: got %h expected 2", rd); end
        apb_read(32'h3C, rd);
        vec_cnt++; if (rd !== 32'h1) begin err_cnt++; $display("FAIL toggle_high: got %h expected 1", rd); end
        apb_write(32'h30, 32'h0);
    endtask

    task automatic test_const_high();
        logic [31:0] rd;
        apb_write(32'h24, 32'h3);
        cap_in[2] = 1'b1;
        step(5);
        apb_write(32'h20, 32'h1);
        step(50);
        apb_read(32'h24, rd);
        vec_cnt++; if (rd !== 32'h4) begin err_cnt++; $display("FAIL const_high_status: got %h expected 4", rd); end
        apb_read(32'h28, rd);
        vec_cnt++; if (rd !== 32'h10) begin err_cnt++; $display("FAIL const_high_period: got %h expected 10", rd); end
        apb_write(32'h20, 32'h0);
        cap_in[2] = 1'b0;
    endtask

    task automatic test_w1c_race();
        logic [31:0] rd;
        apb_write(32'h00, 32'h3);
        cap_in[0] = 1'b1; step(4);
        cap_in[0] = 1'b0; step(4);
        cap_in[0] = 1'b1; step(4);
        cap_in[0] = 1'b0; step(4);
        cap_in[0] = 1'b1; step(1);
        apb_write(32'h04, 32'h1);
        apb_read(32'h04, rd);
        vec_cnt++; if (rd[0] !== 1'b1) begin err_cnt++; $display("FAIL race_valid: got %b expected 1", rd[0]); end
        vec_cnt++; if (irq !== 1'b1) begin err_cnt++; $display("FAIL race_irq: got %b expected 1", irq); end
        apb_read(32'h08, rd);
        vec_cnt++; if (rd !== 32'h8) begin err_cnt++; $display("FAIL race_period: got %h expected 8", rd); end
        apb_read(32'h0C, rd);
        vec_cnt++; if (rd !== 32'h4) begin err_cnt++; $display("FAIL race_high: got %h expected 4", rd); end
        apb_write(32'h04, 32'h1);
        apb_read(32'h04, rd);
        vec_cnt++; if (rd[0] !== 1'b0) begin err_cnt++; $display("FAIL race_plain_w1c: got %b expected 0", rd[0]); end
        cap_in[0] = 1'b0;
        apb_write(32'h00, 32'h0);
    endtask

    task automatic test_disable_reset();
        logic [31:0] rd;
        apb_write(32'h30, 32'h1);
        gen_start(3, 16, 4);
        step(60);
        apb_read(32'h38, rd);
        vec_cnt++; if (rd !== 32'h10) begin err_cnt++; $display("FAIL dis_pre_period: got %h expected 10", rd); end
        apb_write(32'h30, 32'h0);
        gen_start(3, 10, 3);
        step(60);
        apb_read(32'h38, rd);
        vec_cnt++; if (rd !== 32'h10) begin err_cnt++; $display("FAIL dis_kept_period: got %h expected 10", rd); end
        apb_read(32'h3C, rd);
        vec_cnt++; if (rd !== 32'h4) begin err_cnt++; $display("FAIL dis_kept_high: got %h expected 4", rd); end
        gen_stop(3);
        step(5);
        apb_write(32'h34, 32'h3);
        apb_write(32'h30, 32'h1);
        cap_in[3] = 1'b1; step(3);
        cap_in[3] = 1'b0; step(3);
        apb_read(32'h34, rd);
        vec_cnt++; if (rd !== 32'h0) begin err_cnt++; $display("FAIL reen_arm_only: got %h expected 0", rd); end
        cap_in[3] = 1'b1; step(10);
        cap_in[3] = 1'b0; step(5);
        apb_read(32'h38, rd);
        vec_cnt++; if (rd !== 32'h8) begin err_cnt++; $display("FAIL reen_period: got %h expected 8", rd); end
        apb_read(32'h3C, rd);
        vec_cnt++; if (rd !== 32'h3) begin err_cnt++; $display("FAIL reen_high: got %h expected 3", rd); end

        // Reset while a measurement is running with an interrupt pending.
        apb_write(32'h30, 32'h3);
        gen_start(3, 16, 4);
        step(40);
        vec_cnt++; if (irq !== 1'b1) begin err_cnt++; $display("FAIL rst_pre_irq: got %b expected 1", irq); end
        step(5);
        n_rst = 1'b0;
        step(2);
        n_rst = 1'b1;
        step(1);
        #1;
        vec_cnt++; if (irq !== 1'b0) begin err_cnt++; $display("FAIL rst_irq: got %b expected 0", irq); end
        apb_read(32'h30, rd);
        vec_cnt++; if (rd !== 32'h0) begin err_cnt++; $display("FAIL rst_ctrl: got %h expected 0", rd); end
        apb_read(32'h34, rd);
        vec_cnt++; if (rd[1:0] !== 2'b00) begin err_cnt++; $display("FAIL rst_status: got %h expected 0", rd[1:0]); end
        apb_read(32'h38, rd);
        vec_cnt++; if (rd !== 32'h0) begin err_cnt++; $display("FAIL rst_period: got %h expected 0", rd); end
        apb_read(32'h3C, rd);
        vec_cnt++; if (rd !== 32'h0) begin err_cnt++; $display("FAIL rst_high: got %h expected 0", rd); end
        apb_read(32'h18, rd);
        vec_cnt++; if (rd !== 32'h0) begin err_cnt++; $display("FAIL rst_ch1_period: got %h expected 0", rd); end
        gen_stop(3);
    endtask

    initial begin
        n_rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'h0; pwdata = 32'h0; cap_in = 4'h0; gen_en = 4'h0;
        test_reset();
        test_basic();
        test_independence();
        test_overflow();
        test_toggle();
        test_const_high();
        test_w1c_race();
        test_disable_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- APB-slave input-capture peripheral. It sits directly downstream of the PWM generator: its cap_in lines take PWM waveforms, either looped back from pwm_out or from an external pin.
- Per channel, it measures the period and the high time of the incoming waveform in clk cycles and exposes them through memory-mapped registers.
- It raises a level interrupt when a new measurement completes.
- It shares the generator's APB address/data conventions, so the same bus fabric and bench style apply.

Parameters:
- NUM_CHANNELS, 4: number of independent capture channels (1..8).
- CNT_W, 32: width of the cycle counters and of the PERIOD/HIGH registers (8..32).

Ports:
- clk  input  1  system clock; every flop is on its rising edge.
- n_rst  input  1  reset, synchronous, active-low.
- paddr  input  32  APB byte address; bits [1:0] are ignored.
- pwdata  input  32  APB write data.
- psel  input  1  APB select.
- penable  input  1  APB enable (access phase).
- pwrite  input  1  APB direction; 1 = write.
- prdata  output  32  APB read data.
- cap_in  input  NUM_CHANNELS  asynchronous waveforms to measure.
- irq  output  1  OR over channels of (STATUS.valid & CTRL.irq_en).

Behaviour:
- Register map: channel c, index r sits at byte address (c*4 + r)*4.
  - r=0 CTRL (RW): bit0 enable, bit1 irq_en.
  - r=1 STATUS: bit0 valid (W1C), bit1 overflow (W1C), bit2 synced input level (RO).
  - r=2 PERIOD (RO).
  - r=3 HIGH (RO).
  - Unused bits read 0.
- APB write: commits on the clk edge where psel & penable & pwrite are all 1. There are no wait states and pslverr is not implemented. Writes to RO fields and to out-of-range addresses are ignored.
- APB read: prdata is combinational from paddr while psel=1. It is 0 when psel=0 and 0 for out-of-range addresses. A read has no side effects.
- Reset (n_rst=0 at a clk edge): all registers, counters, synchronizers and FSMs clear to 0 and states go to IDLE; prdata=0 and irq=0. This applies mid-measurement too: a partial measurement is discarded.
- Input path: a 2-flop synchronizer per channel, then a third flop for edge detection. rise = s & ~s_d; fall = ~s & s_d.
- Latency: PERIOD, HIGH and valid update 3 clk edges after the cap_in transition that completes a period.
- Per-channel FSM:
  - IDLE, entered whenever enable=0: cnt=0, no captures.
  - ARM, entered from IDLE when enable=1: waits for the first rise. On that rise, cnt is set to 0 and the FSM goes to MEAS.
  - MEAS: cnt increments each cycle and saturates at 2^CNT_W-1.
    - On fall: hi_tmp <= cnt+1, saturating.
    - On rise: PERIOD <= cnt+1 and HIGH <= hi_tmp, both saturating; valid <= 1; cnt <= 0; hi_tmp <= 0.
    - If cnt was saturated at the rise, overflow <= 1 and PERIOD = all ones.
  - Clearing enable returns the FSM to IDLE on the next edge. PERIOD, HIGH and STATUS keep their values.
- Result: for a waveform with period P and high time H cycles, PERIOD=P and HIGH=H from the second rising edge onward. The first rise after enabling only arms the channel.
- No fall during a period (constant high): HIGH = 0.
- Simultaneous W1C write and a new capture in the same cycle: the capture wins and valid stays 1.
- Overwrite: a new capture overwrites PERIOD and HIGH even when valid is already 1. Software reads PERIOD/HIGH before clearing valid.
- irq is registered-free: a combinational OR of flop outputs.

Decomposition:
- Package pwm_capture_pkg holds:
  - the register index constants CTRL_IDX=0, STATUS_IDX=1, PERIOD_IDX=2, HIGH_IDX=3, and REGS_PER_CHAN=4;
  - the STATUS/CTRL bit positions;
  - the FSM state enum cap_state_t {IDLE, ARM, MEAS}.
- Sub-module capture_channel is instantiated NUM_CHANNELS times. It contains the synchronizer, edge detect, FSM, counters, and the PERIOD/HIGH/valid/overflow storage.
- The top level contains the APB decode, the CTRL registers, the read mux and the irq OR.

Test Plan:
- Reset and idle: hold n_rst=0 for 2 cycles, then release and read every address. Expect all 0, irq=0. Read address 0x40: expect 0.
- Basic capture: ch0 CTRL=0x3; drive cap_in[0] with P=16, H=4 (duty 0x4 / period 0x10). Expect after the second rise: PERIOD=16, HIGH=4, STATUS=0x1 or 0x5, irq=1. Write STATUS=0x1: expect irq=0 on the next cycle.
- Per-channel independence: drive channels 0..3 with H=1, 4, 8, 10 and P=16, all enabled. Read back each channel: PERIOD=0x10 and HIGH=0x1, 0x4, 0x8, 0xA respectively. Writing ch2 CTRL has no effect on the other channels.
- Overflow: CNT_W=8, cap_in period 300 cycles. Expect PERIOD=0xFF and overflow=1. W1C 0x2 clears overflow.
- Boundary cases:
  - Constant-high cap_in after arming: no capture ever occurs (no rise).
  - Toggling every cycle (P=2, H=1): PERIOD=2, HIGH=1.
  - W1C on the same cycle as a capture rise: valid remains 1.
- Disable and reset mid-measurement: clear enable mid-period; expect no new capture and PERIOD retained. Re-enable: the first rise only arms. Asserting n_rst mid-period clears everything.
